// File: rtl/alu_seq.sv
// alu_seq: sequential 8-bit ALU with a START/BUSY/DONE handshake.
//
// ADD, SUB, AND, OR and XOR, and shifts by zero, finish in one cycle.
// SHL/SHR shift one bit per cycle. MUL is an 8-iteration shift-add that
// keeps the low byte of the product. RESULT and Flags are loaded only on
// the edge that enters WB, so they are stable while FWE is high.
//
// Ports:
//   CLK    in   rising-edge clock
//   RESET  in   asynchronous active-high reset; aborts any operation
//   START  in   operation request, sampled only in IDLE
//   OP     in   3-bit opcode (ADD SUB AND OR XOR SHL SHR MUL)
//   A, B   in   8-bit operands, latched when START is accepted;
//               B[2:0] is the shift count
//   BUSY   out  high in any state other than IDLE
//   DONE   out  one-cycle pulse in WB
//   RESULT out  8-bit result, held until the next WB
//   Flags  out  {CF, OF, NF, ZF}, held with RESULT
//   FWE    out  flag-register write enable, identical to DONE
module alu_seq (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [2:0] OP,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RESULT,
  output logic [3:0] Flags,
  output logic       FWE
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [7:0]  work_q, work_d;     // shift working register
  logic [15:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [7:0]  mplier_q, mplier_d; // multiplier, shifted right each step
  logic [15:0] acc_q, acc_d;       // partial product
  logic [3:0]  cnt_q, cnt_d;       // remaining iterations
  logic [7:0]  result_q, result_d;
  logic [3:0]  flags_q, flags_d;

  // Single-cycle datapath on the raw inputs; the result is written on the
  // same edge that accepts START.
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic       add_ovf;
  logic       sub_ovf;

  assign sum9    = {1'b0, A} + {1'b0, B};
  assign diff9   = {1'b0, A} - {1'b0, B};
  assign add_ovf = (A[7] == B[7]) && (sum9[7] != A[7]);
  assign sub_ovf = (A[7] != B[7]) && (diff9[7] != A[7]);

  // One shift step on the working register.
  logic [7:0] shift_val;
  logic       shift_out;

  always_comb begin
    shift_val = '0;
    shift_out = 1'b0;
    if (op_q == OpShl) begin
      shift_val = {work_q[6:0], 1'b0};
      shift_out = work_q[7];
    end else begin
      shift_val = {1'b0, work_q[7:1]};
      shift_out = work_q[0];
    end
  end

  // One shift-add step of the multiplier.
  logic [15:0] acc_next;
  logic        mul_hi;

  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_hi   = |acc_next[15:8];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          op_d     = OP;
          work_d   = A;
          mcand_d  = {8'h00, A};
          mplier_d = B;
          acc_d    = '0;
          case (OP)
            OpShl, OpShr: begin
              if (B[2:0] == 3'd0) begin
                state_d  = StWb;
                result_d = A;
                flags_d  = {2'b00, A[7], (A == 8'h00)};
              end else begin
                state_d = StExec;
                cnt_d   = {1'b0, B[2:0]};
              end
            end
            OpMul: begin
              state_d = StExec;
              cnt_d   = 4'd8;
            end
            OpAdd: begin
              state_d  = StWb;
              result_d = sum9[7:0];
              flags_d  = {sum9[8], add_ovf, sum9[7], (sum9[7:0] == 8'h00)};
            end
            OpSub: begin
              state_d  = StWb;
              result_d = diff9[7:0];
              // diff9[8] is the borrow, i.e. A < B unsigned
              flags_d  = {diff9[8], sub_ovf, diff9[7], (diff9[7:0] == 8'h00)};
            end
            OpAnd: begin
              state_d  = StWb;
              result_d = A & B;
              flags_d  = {2'b00, result_d[7], (result_d == 8'h00)};
            end
            OpOr: begin
              state_d  = StWb;
              result_d = A | B;
              flags_d  = {2'b00, result_d[7], (result_d == 8'h00)};
            end
            default: begin // OpXor
              state_d  = StWb;
              result_d = A ^ B;
              flags_d  = {2'b00, result_d[7], (result_d == 8'h00)};
            end
          endcase
        end
      end

      StExec: begin
        cnt_d = cnt_q - 4'd1;
        if (op_q == OpMul) begin
          acc_d    = acc_next;
          mcand_d  = {mcand_q[14:0], 1'b0};
          mplier_d = {1'b0, mplier_q[7:1]};
          if (cnt_q == 4'd1) begin
            state_d  = StWb;
            result_d = acc_next[7:0];
            flags_d  = {mul_hi, mul_hi, acc_next[7], (acc_next[7:0] == 8'h00)};
          end
        end else begin
          work_d = shift_val;
          // The final step loads the result on the same edge as WB entry.
          if (cnt_q == 4'd1) begin
            state_d  = StWb;
            result_d = shift_val;
            flags_d  = {shift_out, 1'b0, shift_val[7], (shift_val == 8'h00)};
          end
        end
      end

      StWb: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      work_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign BUSY   = (state_q != StIdle);
  assign DONE   = (state_q == StWb);
  assign FWE    = DONE;
  assign RESULT = result_q;
  assign Flags  = flags_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential 8-bit ALU that produces results and the 4-bit condition-flag vector, and pulses the flag write-enable consumed by the CPU flag register. Single-cycle ops (ADD/SUB/logic) take one execute cycle; shifts iterate one bit per cycle; MUL is an 8-cycle shift-add. A START/BUSY/DONE handshake with the control unit gates each operation. The one-cycle FWE pulse is coincident with a valid Flags vector.

## Interface
Parameters: none; width fixed at 8 bits.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- START  input  1  request; sampled only in IDLE
- OP  input  3  000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (low byte)
- A  input  8  operand A; latched when START is accepted
- B  input  8  operand B; latched when START is accepted; B[2:0] is the shift count for SHL/SHR
- BUSY  output  1  high in any state other than IDLE
- DONE  output  1  one-cycle pulse in WB
- RESULT  output  8  result; updated on entry to WB, held until the next WB
- Flags  output  4  {CF, OF, NF, ZF}; updated with RESULT and held
- FWE  output  1  flag write-enable; identical to DONE

## Operation
- States: IDLE, EXEC, WB.
- IDLE:
  - START=1 latches OP/A/B.
  - OP 000–100, or a shift with count 0: go to WB.
  - SHL/SHR with count>0, and MUL: go to EXEC.
- EXEC:
  - Shift: one bit per cycle until the count reaches 0, then WB. Runs n cycles.
  - MUL: 8 iterations of a 16-bit shift-add product, then WB.
- WB: DONE=FWE=1 for one cycle; the next edge returns to IDLE unconditionally.
- START outside IDLE (EXEC or WB) is ignored; it is not queued.
- Flag rules:
  - NF = RESULT[7].
  - ZF = (RESULT == 0).
  - ADD: CF = carry out of bit 7; OF = signed overflow.
  - SUB: CF = borrow (A < B unsigned); OF = signed overflow of A−B.
  - AND/OR/XOR: CF = OF = 0.
  - SHL/SHR: CF = last bit shifted out (0 when count = 0); OF = 0.
  - MUL: RESULT = product[7:0]; CF = OF = (product[15:8] ≠ 0).
- Reset values: state=IDLE, BUSY=0, DONE=0, FWE=0, RESULT=8'h00, Flags=4'h0.
- Reset mid-operation: the operation aborts immediately, outputs return to reset values, and no FWE is issued. After RESET deasserts, the first rising edge may accept START.

## Timing
- START is accepted at edge T0.
- Single-cycle ops: WB during cycle T0→T1, so DONE/FWE are high after edge T0. Latency 1 cycle.
- Shift by n (1–7): n EXEC cycles + WB. DONE is high after edge T0+n.
- MUL: 8 EXEC cycles + WB. DONE is high after edge T0+8.
- Minimum START-to-START spacing is 2 cycles for single-cycle ops, because WB must return to IDLE first.
- RESULT and Flags are stable whenever FWE=1.
- RESULT and Flags change only on the edge entering WB, or on reset.

## Test plan
- ADD A=0x7F, B=0x01 → RESULT 0x80, Flags 4'h6 (OF, NF). DONE=FWE=1 for exactly one cycle, 1 cycle after START.
- SUB 0x05−0x05 → 0x00, Flags 4'h1. SUB 0x00−0x01 → 0xFF, Flags 4'hA (CF, NF).
- SHL A=0x81, B=0x01 → 0x02, Flags 4'h8, DONE after 2 cycles. SHR A=0x01, B=0x00 → 0x01, Flags 4'h0, DONE after 1 cycle.
- MUL 0x10×0x10 → RESULT 0x00, Flags 4'hD, DONE after 9 cycles, BUSY high throughout.
- MUL 0x0C×0x0B → 0x84, Flags 4'h2.
- START pulsed during an ongoing MUL is ignored: exactly one DONE, with the original result.
- Asserting RESET asynchronously 4 cycles into a MUL → BUSY, DONE, FWE, RESULT and Flags all return to 0 immediately, and no FWE pulse follows. A new ADD issued after reset completes normally.
